// File: rtl/audio_hex_monitor.sv
// rtl/audio_hex_monitor.sv - multi-channel audio sample monitor feeding hex displays
//
// Captures per-channel samples on sample_stb, tracks per-channel peak magnitude
// and sticky clip flags, and latches a selected view (live / peak-hold / freeze)
// into disp_out once per refresh period.
//
// Optional feature macro: PEAK_DECAY_EN (peak decays by 1/8 at each refresh event).
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   AUD_DACLRCK   in   asynchronous active-low reset
//   samples_in    in   NUM_CH*SAMPLE_W, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   sample_stb    in   samples_in valid this cycle
//   mode          in   00 live, 01 peak-hold, 10/11 freeze
//   clear_peak    in   clear peak registers and clip flags
//   disp_out      out  displayed value per channel, same packing as samples_in
//   refresh_tick  out  one-cycle pulse coincident with a disp_out update
//   clip          out  sticky per-channel clip flag
module audio_hex_monitor #(
  parameter int NUM_CH         = 2,
  parameter int SAMPLE_W       = 16,
  parameter int REFRESH_CYCLES = 5000000
) (
  input  logic                         CLOCK_50,
  input  logic                         AUD_DACLRCK,
  input  logic [NUM_CH*SAMPLE_W-1:0]   samples_in,
  input  logic                         sample_stb,
  input  logic [1:0]                   mode,
  input  logic                         clear_peak,
  output logic [NUM_CH*SAMPLE_W-1:0]   disp_out,
  output logic                         refresh_tick,
  output logic [NUM_CH-1:0]            clip
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0]       TC       = CW'(REFRESH_CYCLES - 1);
  localparam logic [SAMPLE_W-1:0] MAX_POS  = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-2:0] MAG_SAT  = {(SAMPLE_W-1){1'b1}};
  localparam logic [SAMPLE_W-2:0] MAG_ONE  = {{(SAMPLE_W-2){1'b0}}, 1'b1};

  logic [CW-1:0]       cnt;
  logic                refresh_ev;
  logic [1:0]          mode_q;
  logic [SAMPLE_W-1:0] live     [NUM_CH];
  logic [SAMPLE_W-1:0] peak     [NUM_CH];
  logic [SAMPLE_W-1:0] peak_nxt [NUM_CH];
  logic [SAMPLE_W-1:0] smp      [NUM_CH];
  logic [SAMPLE_W-2:0] mag      [NUM_CH];
  logic [NUM_CH-1:0]   hit;

  assign refresh_ev = (cnt == TC);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      smp[c] = samples_in[c*SAMPLE_W +: SAMPLE_W];
      // Negation only needs the low SAMPLE_W-1 bits; most-negative saturates.
      if (smp[c] == MOST_NEG)
        mag[c] = MAG_SAT;
      else if (smp[c][SAMPLE_W-1])
        mag[c] = ~smp[c][SAMPLE_W-2:0] + MAG_ONE;
      else
        mag[c] = smp[c][SAMPLE_W-2:0];
      hit[c] = (smp[c] == MAX_POS) || (smp[c] == MOST_NEG);

      peak_nxt[c] = peak[c];
`ifdef PEAK_DECAY_EN
      // Decay applies after this event's display latch (disp uses the old peak).
      if (refresh_ev)
        peak_nxt[c] = peak[c] - (peak[c] >> 3);
`endif
      if (sample_stb && ({1'b0, mag[c]} > peak_nxt[c]))
        peak_nxt[c] = {1'b0, mag[c]};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      cnt          <= '0;
      mode_q       <= 2'b00;
      refresh_tick <= 1'b0;
      disp_out     <= '0;
      clip         <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        live[c] <= '0;
        peak[c] <= '0;
      end
    end else begin
      cnt          <= refresh_ev ? '0 : cnt + CW'(1);
      refresh_tick <= refresh_ev;

      // Display uses the mode sampled at the previous event, giving a fixed
      // one-period lag between a mode change and its effect.
      if (refresh_ev) begin
        mode_q <= mode;
        for (int c = 0; c < NUM_CH; c++) begin
          case (mode_q)
            2'b00:   disp_out[c*SAMPLE_W +: SAMPLE_W] <= live[c];
            2'b01:   disp_out[c*SAMPLE_W +: SAMPLE_W] <= peak[c];
            default: disp_out[c*SAMPLE_W +: SAMPLE_W] <= disp_out[c*SAMPLE_W +: SAMPLE_W];
          endcase
        end
      end

      for (int c = 0; c < NUM_CH; c++) begin
        if (sample_stb)
          live[c] <= smp[c];
        // clear_peak discards any coincident sample's magnitude and clip.
        if (clear_peak) begin
          peak[c] <= '0;
          clip[c] <= 1'b0;
        end else begin
          peak[c] <= peak_nxt[c];
          if (sample_stb && hit[c])
            clip[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/audio_hex_monitor.md
Name: audio_hex_monitor

Overview:
Parametrised multi-channel audio sample monitor for the FX generator debug path. Captures per-channel samples on a frame strobe and tracks per-channel peak magnitude and sticky clip flags. Latches a selectable view (live, peak-hold, freeze) into a nibble-packed display register on a programmable refresh period. Display nibbles feed the existing HexDriver instances.

Parameters:
NUM_CH, 2, number of audio channels (ch0 = L, ch1 = R, ...)
SAMPLE_W, 16, sample width in bits, two's complement; must be a multiple of 4
REFRESH_CYCLES, 5000000, display refresh period in CLOCK_50 cycles; must be >= 2

Ports:
CLOCK_50  in  1  system clock; all logic on its rising edge
AUD_DACLRCK  in  1  reset, asynchronous, active-low
samples_in  in  NUM_CH*SAMPLE_W  channel c occupies bits [c*SAMPLE_W +: SAMPLE_W]; already in CLOCK_50 domain
sample_stb  in  1  one-cycle pulse: samples_in valid this cycle
mode  in  2  00 live, 01 peak-hold, 10/11 freeze
clear_peak  in  1  synchronous clear of peak registers and clip flags
disp_out  out  NUM_CH*SAMPLE_W  displayed value per channel, same packing as samples_in; nibble n of channel c drives one hex digit
refresh_tick  out  1  one-cycle pulse on the cycle disp_out updates
clip  out  NUM_CH  sticky per-channel clip flag

Behaviour:
- Reset (AUD_DACLRCK low, async assert, sync-to-clock release): disp_out=0, refresh_tick=0, clip=0, live/peak registers=0, refresh counter=0, mode_q=00.
- Refresh counter: counts 0..REFRESH_CYCLES-1, wraps to 0; exact period REFRESH_CYCLES. Terminal-count cycle = refresh event. refresh_tick registered: high for exactly the one cycle after the event edge, coincident with the new disp_out.
- Live capture: sample_stb high at edge t -> live[c]=samples_in[c] visible at t+1. No stb -> hold.
- Peak: mag = |sample|, unsigned SAMPLE_W-1 bits; most-negative input (0x8000 at W=16) saturates to 0x7FFF. On sample_stb, peak[c] <= max(peak[c], mag). Peak stored zero-extended to SAMPLE_W.
- Clip: on sample_stb, clip[c] set if sample = max positive (0x7FFF) or most negative (0x8000). Sticky.
- clear_peak: peak=0, clip=0 next cycle; wins over simultaneous sample_stb for peak/clip (that sample's mag/clip discarded); live capture still occurs.
- Mode sampling: mode registered into mode_q only on refresh events; mid-period mode changes take effect at next refresh event.
- Display latch on refresh event per mode_q (value before this event's update): 00 disp=live (raw two's complement), 01 disp=peak, 10/11 disp holds. Counter, refresh_tick, live, peak, clip keep running in freeze.
- Simultaneous sample_stb and refresh event: display takes pre-stb register contents; new sample appears at next refresh.
- Mode change path: event k samples new mode; event k+1 applies it (deterministic one-period lag).
- No backpressure; strobes arriving faster than refresh simply overwrite live.

Optional Feature:
Macro PEAK_DECAY_EN.
- Defined: at each refresh event, after the display latch, peak[c] <= peak[c] - (peak[c] >> 3), floor 0. If sample_stb coincides, peak[c] <= max(decayed, mag). clear_peak still wins.
- Undefined: peak holds until clear_peak or reset; no decay logic synthesised.

Test Plan:
(Sim params: NUM_CH=2, SAMPLE_W=16, REFRESH_CYCLES=8.)
1. Reset: hold AUD_DACLRCK low 3 cycles, release -> disp_out=0, clip=00; first refresh_tick exactly 8 cycles after release, then every 8 cycles.
2. Live: mode=00, stb with ch0=0x1234, ch1=0xFEDC -> after second refresh event (mode lag), disp_out ch0=0x1234, ch1=0xFEDC coincident with refresh_tick.
3. Peak/saturation: mode=01, stb ch0 sequence 0x0100, 0xFF00, 0x8000 -> peak ch0=0x7FFF, clip[0]=1, clip[1]=0; next refresh disp ch0=0x7FFF.
4. Clear priority: stb ch0=0x7FFF together with clear_peak -> peak ch0=0, clip[0]=0, live ch0=0x7FFF.
5. Freeze: disp showing 0x1234, mode=10, stb 0x5555 repeatedly for 4 periods -> disp_out unchanged, refresh_tick still pulses; mode=00 -> 0x5555 after 2 events.
6. PEAK_DECAY_EN defined: peak=0x0800, no stb -> after refresh events peak 0x0700, 0x0620; undefined -> stays 0x0800.
